pokey_ctrl_scanner: RTL and testbench

Parametrised, clocked controller front end for POKEY's keyboard scan path. Replaces the purely combinational keypad mux. Raw active-low controller contacts pass through a synchronizer and per-key debounce. The POKEY scan address `key_scan_L` selects one debounced key per cycle and drives `kr1_L`, and the addressed port's side button drives `kr2_L`. A one-entry key-event register with a valid/ack handshake reports new presses to the host-side logic.

---
 rtl/pokey_ctrl_scanner.sv | 178 +++++++++++++++++
 tb/tb_pokey_ctrl_scanner.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_ctrl_scanner.sv
// Clocked POKEY keyboard-scan front end: synchronizes and debounces controller
// contacts, muxes the scanned key/side button onto kr1_L/kr2_L, and latches key presses.
module pokey_ctrl_scanner #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned KEYS_PER_PORT   = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_L,
    input  logic [5:0]                           key_scan_L,
    input  logic [NUM_PORTS*KEYS_PER_PORT-1:0]   ctrl_in_L,
    input  logic [NUM_PORTS-1:0]                 side_btn_L,
    output logic                                 kr1_L,
    output logic                                 kr2_L,
    output logic                                 evt_valid,
    output logic [1:0]                           evt_port,
    output logic [3:0]                           evt_key,
    output logic                                 evt_ovf,
    input  logic                                 evt_ack
);

    localparam int unsigned NK = NUM_PORTS * KEYS_PER_PORT;
    localparam int unsigned NB = NK + NUM_PORTS;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0] sync_q [SYNC_STAGES];
    logic [NB-1:0] sync_d [SYNC_STAGES];
    logic [NB-1:0] stable_q, stable_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [NB-1:0] synced_c;
    logic [NK-1:0] press_c;
    logic [5:0]    scan_c;
    logic [1:0]    ps_c;
    logic [3:0]    ks_c;

    logic          kr1_q, kr1_d, kr2_q, kr2_d;
    logic          valid_q, valid_d, ovf_q, ovf_d;
    logic [1:0]    port_q, port_d;
    logic [3:0]    key_q, key_d;
    logic          found_c, extra_c, ack_take_c;
    logic [1:0]    cap_port_c;
    logic [3:0]    cap_key_c;

    // Bit layout: keypad contacts in [NK-1:0], side buttons above them.
    always_comb begin
        sync_d[0] = {side_btn_L, ctrl_in_L};
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign synced_c = sync_q[SYNC_STAGES-1];

    // Stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (synced_c[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press_c = stable_q[NK-1:0] & ~stable_d[NK-1:0];

    assign scan_c = ~key_scan_L;
    assign ps_c   = scan_c[5:4];
    assign ks_c   = scan_c[3:0];

    // Unmatched (out-of-range) selections fall through to the released level.
    always_comb begin
        kr1_d = 1'b1;
        kr2_d = 1'b1;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (ps_c == 2'(p)) begin
                kr2_d = stable_q[NK + p];
                for (int unsigned k = 0; k < KEYS_PER_PORT; k++) begin
                    if (ks_c == 4'(k)) begin
                        kr1_d = stable_q[p*KEYS_PER_PORT + k];
                    end
                end
            end
        end
    end

    // Lowest flat index wins; any additional simultaneous press is an overflow.
    always_comb begin
        found_c    = 1'b0;
        extra_c    = 1'b0;
        cap_port_c = '0;
        cap_key_c  = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned k = 0; k < KEYS_PER_PORT; k++) begin
                if (press_c[p*KEYS_PER_PORT + k]) begin
                    if (!found_c) begin
                        found_c    = 1'b1;
                        cap_port_c = 2'(p);
                        cap_key_c  = 4'(k);
                    end else begin
                        extra_c = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        port_d     = port_q;
        key_d      = key_q;
        ack_take_c = evt_ack && valid_q;
        if (ack_take_c) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
        if (found_c) begin
            if (!valid_q || ack_take_c) begin
                valid_d = 1'b1;
                port_d  = cap_port_c;
                key_d   = cap_key_c;
                if (extra_c) begin
                    ovf_d = 1'b1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '1;
            kr1_q    <= 1'b1;
            kr2_q    <= 1'b1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            port_q   <= '0;
            key_q    <= '0;
        end else begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            kr1_q    <= kr1_d;
            kr2_q    <= kr2_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            port_q   <= port_d;
            key_q    <= key_d;
        end
    end

    assign kr1_L     = kr1_q;
    assign kr2_L     = kr2_q;
    assign evt_valid = valid_q;
    assign evt_port  = port_q;
    assign evt_key   = key_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_pokey_ctrl_scanner.sv
// Bench for pokey_ctrl_scanner: directed sequences, a scan/mux vector table, and random
// stimulus, all compared against a behavioural model of debounce, mux and event rules.
module tb_pokey_ctrl_scanner;

    localparam int NP = 2;
    localparam int KP = 12;
    localparam int DB = 4;
    localparam int SS = 2;
    localparam int NK = NP * KP;
    localparam int NB = NK + NP;

    logic          clk;
    logic          rst_L;
    logic [5:0]    key_scan_L;
    logic [NK-1:0] ctrl_in_L;
    logic [NP-1:0] side_btn_L;
    logic          kr1_L, kr2_L, evt_valid, evt_ovf, evt_ack;
    logic [1:0]    evt_port;
    logic [3:0]    evt_key;

    pokey_ctrl_scanner #(
        .NUM_PORTS(NP), .KEYS_PER_PORT(KP), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst_L(rst_L), .key_scan_L(key_scan_L), .ctrl_in_L(ctrl_in_L),
        .side_btn_L(side_btn_L), .kr1_L(kr1_L), .kr2_L(kr2_L), .evt_valid(evt_valid),
        .evt_port(evt_port), .evt_key(evt_key), .evt_ovf(evt_ovf), .evt_ack(evt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: levels accepted after DB consecutive disagreeing synced samples.
    logic [NB-1:0] m_stable;
    int            m_run [NB];
    logic [NB-1:0] m_hist [$];
    logic          m_valid, m_ovf, m_kr1, m_kr2;
    int            m_port, m_key;

    function automatic logic key_at(input logic [NB-1:0] st, input logic [5:0] scl);
        logic [5:0] sc;
        int ps, ks;
        sc = ~scl;
        ps = int'(sc[5:4]);
        ks = int'(sc[3:0]);
        if (ps < NP && ks < KP) return st[ps*KP + ks];
        return 1'b1;
    endfunction

    function automatic logic side_at(input logic [NB-1:0] st, input logic [5:0] scl);
        logic [5:0] sc;
        int ps;
        sc = ~scl;
        ps = int'(sc[5:4]);
        if (ps < NP) return st[NK + ps];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_stable = '1;
        for (int b = 0; b < NB; b++) m_run[b] = 0;
        m_hist.delete();
        m_valid = 1'b0; m_ovf = 1'b0; m_kr1 = 1'b1; m_kr2 = 1'b1;
        m_port = 0; m_key = 0;
    endtask

    task automatic model_step(input logic [NB-1:0] raw, input logic [5:0] scl, input logic ack);
        logic [NB-1:0] synced;
        int presses [$];
        m_kr1 = key_at(m_stable, scl);
        m_kr2 = side_at(m_stable, scl);
        synced = (m_hist.size() >= SS) ? m_hist[m_hist.size() - SS] : '1;
        m_hist.push_back(raw);
        if (m_hist.size() > SS) void'(m_hist.pop_front());
        for (int b = 0; b < NB; b++) begin
            if (synced[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_run[b] = 0;
                    if (b < NK && m_stable[b]) presses.push_back(b);
                    m_stable[b] = ~m_stable[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        if (ack && m_valid) begin
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end
        if (presses.size() > 0) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_port  = presses[0] / KP;
                m_key   = presses[0] % KP;
                if (presses.size() > 1) m_ovf = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic tick();
        logic [NB-1:0] raw;
        logic [5:0]    sc;
        logic          ak;
        raw = {side_btn_L, ctrl_in_L};
        sc  = key_scan_L;
        ak  = evt_ack;
        @(posedge clk);
        model_step(raw, sc, ak);
        #1;
        check("model", 32'({kr1_L, kr2_L, evt_valid, evt_port, evt_key, evt_ovf}),
              32'({m_kr1, m_kr2, m_valid, 2'(m_port), 4'(m_key), m_ovf}));
    endtask

    task automatic check_evt(input string name, input logic v, input int p, input int k, input logic o);
        check(name, 32'({evt_valid, evt_port, evt_key, evt_ovf}), 32'({v, 2'(p), 4'(k), o}));
    endtask

    task automatic settle();
        ctrl_in_L  = '1;
        side_btn_L = '1;
        evt_ack    = 1'b1;
        repeat (10) tick();
        evt_ack    = 1'b0;
    endtask

    typedef struct {
        logic [5:0]    scan;
        logic [NK-1:0] ctrl;
        logic [NP-1:0] side;
        logic          kr1;
        logic          kr2;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{6'h05, ~24'h000020, 2'b11, 1'b0, 1'b1};
        vecs[1] = '{6'h15, ~24'h020000, 2'b11, 1'b0, 1'b1};
        vecs[2] = '{6'h1B, ~24'h800000, 2'b11, 1'b0, 1'b1};
        vecs[3] = '{6'h0C, 24'h000000,  2'b11, 1'b1, 1'b1};
        vecs[4] = '{6'h10, 24'hFFFFFF,  2'b01, 1'b1, 1'b0};
        vecs[5] = '{6'h00, ~24'h000001, 2'b10, 1'b0, 1'b0};
        vecs[6] = '{6'h25, 24'h000000,  2'b00, 1'b1, 1'b1};
        vecs[7] = '{6'h3F, 24'h000000,  2'b00, 1'b1, 1'b1};
        vecs[8] = '{6'h1B, ~24'h400000, 2'b11, 1'b1, 1'b1};

        rst_L = 1'b0; key_scan_L = '1; ctrl_in_L = '1; side_btn_L = '1; evt_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'({kr1_L, kr2_L, evt_valid, evt_port, evt_key, evt_ovf}), 32'(10'b11_0_00_0000_0));
        rst_L = 1'b1;
        tick();
        check_evt("idle_evt", 1'b0, 0, 0, 1'b0);
        for (int s = 0; s < 64; s++) begin
            key_scan_L = ~6'(s);
            tick();
            check("idle_kr1", 32'(kr1_L), 32'd1);
        end

        // Press latency with default parameters.
        key_scan_L = ~6'h05;
        tick();
        ctrl_in_L[5] = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 5) check_evt("lat_e5", 1'b0, 0, 0, 1'b0);
            if (t == 6) begin
                check_evt("lat_e6", 1'b1, 0, 5, 1'b0);
                check("lat_kr1_e6", 32'(kr1_L), 32'd1);
            end
            if (t == 7) check("lat_kr1_e7", 32'(kr1_L), 32'd0);
        end
        key_scan_L = ~6'h04;
        tick();
        check("scan_change_kr1", 32'(kr1_L), 32'd1);
        settle();
        check_evt("release_no_evt", 1'b0, 0, 5, 1'b0);

        // Glitch rejection, then a pulse just long enough.
        key_scan_L = ~6'h15;
        ctrl_in_L[17] = 1'b0;
        repeat (3) tick();
        ctrl_in_L[17] = 1'b1;
        repeat (10) begin
            tick();
            check("glitch_kr1", 32'(kr1_L), 32'd1);
            check("glitch_evt", 32'(evt_valid), 32'd0);
        end
        ctrl_in_L[17] = 1'b0;
        repeat (4) tick();
        ctrl_in_L[17] = 1'b1;
        repeat (2) tick();
        check_evt("pulse4_evt", 1'b1, 1, 5, 1'b0);
        settle();

        // Simultaneous presses.
        ctrl_in_L[3] = 1'b0;
        ctrl_in_L[14] = 1'b0;
        repeat (6) tick();
        check_evt("simul_evt", 1'b1, 0, 3, 1'b1);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check("simul_ack_v", 32'({evt_valid, evt_ovf}), 32'd0);
        settle();

        // Ack on the same edge a new press stabilises.
        ctrl_in_L[0] = 1'b0;
        repeat (6) tick();
        check_evt("coll_first", 1'b1, 0, 0, 1'b0);
        ctrl_in_L[20] = 1'b0;
        repeat (5) tick();
        check_evt("coll_hold", 1'b1, 0, 0, 1'b0);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check_evt("coll_reload", 1'b1, 1, 8, 1'b0);
        settle();

        // Out-of-range key select versus an in-range pressed key.
        ctrl_in_L = '0;
        evt_ack = 1'b1;
        repeat (8) tick();
        key_scan_L = ~6'h0D;
        tick();
        check("oor_ks13", 32'(kr1_L), 32'd1);
        key_scan_L = ~6'h0B;
        tick();
        check("inr_ks11", 32'(kr1_L), 32'd0);
        settle();

        // Side button path and out-of-range port.
        key_scan_L = ~6'h10;
        side_btn_L[1] = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 6) check("side_e6", 32'(kr2_L), 32'd1);
            if (t == 7) check("side_e7", 32'(kr2_L), 32'd0);
        end
        check("side_no_evt", 32'(evt_valid), 32'd0);
        key_scan_L = ~6'h30;
        tick();
        check("oor_ps3", 32'(kr2_L), 32'd1);
        key_scan_L = ~6'h10;
        tick();
        check("side_back", 32'(kr2_L), 32'd0);

        // Asynchronous reset mid-debounce; held keys re-detected afterwards.
        ctrl_in_L[1] = 1'b0;
        repeat (6) tick();
        check_evt("pre_rst_evt", 1'b1, 0, 1, 1'b0);
        ctrl_in_L[2] = 1'b0;
        repeat (3) tick();
        rst_L = 1'b0;
        #1;
        check("async_rst", 32'({kr1_L, kr2_L, evt_valid, evt_port, evt_key, evt_ovf}), 32'(10'b11_0_00_0000_0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_L = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 5) check_evt("rerst_e5", 1'b0, 0, 0, 1'b0);
            if (t == 6) check_evt("rerst_e6", 1'b1, 0, 1, 1'b1);
            if (t == 7) check("rerst_kr2", 32'(kr2_L), 32'd0);
        end
        settle();

        // Scan/mux vector table with inputs held stable.
        evt_ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            key_scan_L = ~vecs[i].scan;
            ctrl_in_L  = vecs[i].ctrl;
            side_btn_L = vecs[i].side;
            repeat (9) tick();
            check($sformatf("vec%0d_kr1", i), 32'(kr1_L), 32'(vecs[i].kr1));
            check($sformatf("vec%0d_kr2", i), 32'(kr2_L), 32'(vecs[i].kr2));
        end
        settle();

        // Random contacts, scan and ack against the model, with one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NK; b++) begin
                if ($urandom_range(0, 19) == 0) ctrl_in_L[b] = ~ctrl_in_L[b];
            end
            for (int b = 0; b < NP; b++) begin
                if ($urandom_range(0, 19) == 0) side_btn_L[b] = ~side_btn_L[b];
            end
            key_scan_L = 6'($urandom_range(0, 63));
            evt_ack    = ($urandom_range(0, 3) == 0);
            if (n == 1500) begin
                rst_L = 1'b0;
                #1;
                model_reset();
                check("rand_rst", 32'({kr1_L, kr2_L, evt_valid, evt_port, evt_key, evt_ovf}), 32'(10'b11_0_00_0000_0));
                @(posedge clk);
                #1;
                rst_L = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
